spi_arbiter: RTL

SPI_ARBITER -- requirements
Module: spi_arbiter

---
 rtl/spi_arbiter.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/spi_arbiter.sv
// Round-robin arbiter that shares one SPI bus master among NUM_REQ requesters.
// Per grant: 2 setup cycles, a start handshake with timeout, the transfer, settle, then a 1-cycle ack.
module spi_arbiter #(
  parameter int BUS_WIDTH  = 16,
  parameter int NUM_REQ    = 4,
  parameter int START_TMO  = 8,
  parameter int SETTLE_CYC = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [NUM_REQ*BUS_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]           grant,
  output logic [NUM_REQ-1:0]           ack,
  output logic                         err,
  output logic [BUS_WIDTH-1:0]         rx_data,
  output logic [NUM_REQ-1:0]           cs_sel,
  output logic [BUS_WIDTH-1:0]         spi_d_out,
  output logic                         spi_start,
  input  logic                         spi_busy,
  input  logic [BUS_WIDTH-1:0]         spi_d_in
);

  localparam int IW   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CMAX = (START_TMO > SETTLE_CYC) ? START_TMO : SETTLE_CYC;
  localparam int CW   = $clog2(CMAX + 2);
  localparam logic [CW-1:0] TMO_LAST    = CW'((START_TMO  > 0) ? START_TMO  - 1 : 0);
  localparam logic [CW-1:0] SETTLE_LAST = CW'((SETTLE_CYC > 0) ? SETTLE_CYC - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_START, S_XFER, S_SETTLE, S_DONE
  } state_t;

  state_t          state;
  logic [IW-1:0]   ptr;
  logic [IW-1:0]   winner;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   cnt_inc;
  logic [IW-1:0]   pick;
  logic [IW-1:0]   ptr_next;
  logic [NUM_REQ-1:0] pick_oh;
  logic [NUM_REQ-1:0] winner_oh;

  // First asserted request at or after ptr, wrapping modulo NUM_REQ.
  always_comb begin : arb
    int   idx;
    logic found;
    idx   = 0;
    found = 1'b0;
    pick  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = int'(ptr) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && req[IW'(idx)]) begin
        found = 1'b1;
        pick  = IW'(idx);
      end
    end
  end

  assign pick_oh   = {{(NUM_REQ-1){1'b0}}, 1'b1} << pick;
  assign winner_oh = {{(NUM_REQ-1){1'b0}}, 1'b1} << winner;
  assign ptr_next  = (winner == IW'(NUM_REQ - 1)) ? '0 : winner + IW'(1);
  assign cnt_inc   = (cnt == '1) ? cnt : cnt + CW'(1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      ptr       <= '0;
      winner    <= '0;
      cnt       <= '0;
      grant     <= '0;
      cs_sel    <= '0;
      ack       <= '0;
      err       <= 1'b0;
      spi_start <= 1'b0;
      spi_d_out <= '0;
      rx_data   <= '0;
    end else begin
      ack <= '0;
      err <= 1'b0;
      case (state)
        S_IDLE: begin
          if (|req) begin
            winner    <= pick;
            grant     <= pick_oh;
            cs_sel    <= pick_oh;
            spi_d_out <= req_data[int'(pick)*BUS_WIDTH +: BUS_WIDTH];
            cnt       <= '0;
            state     <= S_SETUP;
          end
        end
        S_SETUP: begin
          if (cnt == CW'(1)) begin
            cnt       <= '0;
            spi_start <= 1'b1;
            state     <= S_START;
          end else begin
            cnt <= cnt_inc;
          end
        end
        S_START: begin
          if (spi_busy) begin
            cnt   <= '0;
            state <= S_XFER;
          end else if (cnt >= TMO_LAST) begin
            spi_start <= 1'b0;
            ack       <= winner_oh;
            err       <= 1'b1;
            state     <= S_DONE;
          end else begin
            cnt <= cnt_inc;
          end
        end
        S_XFER: begin
          if (!spi_busy) begin
            spi_start <= 1'b0;
            cnt       <= '0;
            state     <= S_SETTLE;
          end
        end
        S_SETTLE: begin
          if (cnt >= SETTLE_LAST) begin
            rx_data <= spi_d_in;
            ack     <= winner_oh;
            state   <= S_DONE;
          end else begin
            cnt <= cnt_inc;
          end
        end
        S_DONE: begin
          grant  <= '0;
          cs_sel <= '0;
          ptr    <= ptr_next;
          cnt    <= '0;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
